rpn_stack_calculator: RTL

Parametrised reverse-Polish calculator with an internal operand stack of configurable width and depth, driven by a single Enter key plus a data/opcode word. It generalises the lab's fixed two-operand RPN calculator to N-deep stacks, eight opcodes, error reporting and arithmetic flags. It sits between the board switch/button debouncers and the 7-segment display driver.

---
 rtl/rpn_pkg.sv | 49 ++++
 rtl/rpn_alu.sv | 63 ++++++
 rtl/rpn_stack_calculator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack calculator: one-hot states, opcodes, error codes, flag positions.
// Optional multiplier is enabled by defining RPN_MUL_EN.
package rpn_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_DECODE = 5'b00010,
        ST_EXEC   = 5'b00100,
        ST_SHOW   = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_DUP  = 3'd6,
        OP_DROP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Binary ops consume NOS and TOS; DUP/DROP only touch the top entry.
    function automatic logic is_binary(opcode_t op);
        return (op != OP_DUP) && (op != OP_DROP);
    endfunction

    function automatic logic is_legal(opcode_t op);
`ifdef RPN_MUL_EN
        return (op == op);
`else
        return op != OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN calculator: result = NOS op TOS, plus {N,Z,C,V}.
// The multiplier branch exists only when RPN_MUL_EN is defined.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  opcode_t            i_op,
    input  logic [WIDTH-1:0]   i_nos,
    input  logic [WIDTH-1:0]   i_tos,
    output logic [WIDTH-1:0]   o_result,
    output logic [3:0]         o_flags
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_c;
    logic             w_v;

    assign w_sum  = {1'b0, i_nos} + {1'b0, i_tos};
    // The extra top bit of the difference is the unsigned borrow (NOS < TOS).
    assign w_diff = {1'b0, i_nos} - {1'b0, i_tos};

`ifdef RPN_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, i_nos} * {{WIDTH{1'b0}}, i_tos};
`endif

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (i_nos[WIDTH-1] == i_tos[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_nos[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_c      = w_diff[WIDTH];
                w_v      = (i_nos[WIDTH-1] != i_tos[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != i_nos[WIDTH-1]);
            end
            OP_AND: w_result = i_nos & i_tos;
            OP_OR:  w_result = i_nos | i_tos;
            OP_XOR: w_result = i_nos ^ i_tos;
`ifdef RPN_MUL_EN
            OP_MUL: begin
                w_result = w_prod[WIDTH-1:0];
                w_c      = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    assign o_result = w_result;
    assign o_flags  = {w_result[WIDTH-1], (w_result == '0), w_c, w_v};

endmodule

// File: rtl/rpn_stack_calculator.sv
// Top of the RPN calculator: Enter edge detect, one-hot control FSM and register-array operand stack.
// Opcode 5 (MUL) is available only when RPN_MUL_EN is defined; otherwise it reports an illegal opcode.
module rpn_stack_calculator
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       Enter,
    input  logic                       IsOp,
    input  logic [WIDTH-1:0]           DataIn,
    output logic [3:0]                 Flags,
    output logic [WIDTH-1:0]           ToDisplay,
    output logic [4:0]                 CurrentState,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic [1:0]                 Error
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_t           r_state, w_state_next;
    logic             r_enter_prev;
    logic [WIDTH-1:0] r_data, w_data_next;
    logic             r_isop, w_isop_next;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [DW-1:0]    r_depth, w_depth_next;
    logic [WIDTH-1:0] r_nos, w_nos_next;
    logic [WIDTH-1:0] r_tos, w_tos_next;
    opcode_t          r_opcode, w_opcode_next;
    logic [3:0]       r_flags, w_flags_next;
    logic [WIDTH-1:0] r_display, w_display_next;
    err_t             r_error, w_error_next;

    logic             w_edge;
    opcode_t          w_opcode;
    err_t             w_check;
    logic [AW-1:0]    w_top_idx, w_nos_idx, w_push_idx;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;
    logic [WIDTH-1:0] w_alu_result;
    logic [3:0]       w_alu_flags;

    assign w_edge     = Enter & ~r_enter_prev;
    assign w_opcode   = opcode_t'(r_data[2:0]);
    assign w_top_idx  = AW'(r_depth - DW'(1));
    assign w_nos_idx  = AW'(r_depth - DW'(2));
    assign w_push_idx = AW'(r_depth);

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_opcode),
        .i_nos    (r_nos),
        .i_tos    (r_tos),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    // Opcode admission check; order matters when several conditions fail at once.
    always_comb begin
        w_check = ERR_NONE;
        if (!is_legal(w_opcode)) begin
            w_check = ERR_ILLEGAL;
        end else if (is_binary(w_opcode)) begin
            if (r_depth < DW'(2)) w_check = ERR_UNDERFLOW;
        end else if (r_depth == '0) begin
            w_check = ERR_UNDERFLOW;
        end else if ((w_opcode == OP_DUP) && (r_depth == FULL)) begin
            w_check = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_data_next    = r_data;
        w_isop_next    = r_isop;
        w_depth_next   = r_depth;
        w_nos_next     = r_nos;
        w_tos_next     = r_tos;
        w_opcode_next  = r_opcode;
        w_flags_next   = r_flags;
        w_display_next = r_display;
        w_error_next   = r_error;
        w_wr_en        = 1'b0;
        w_wr_idx       = w_push_idx;
        w_wr_data      = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_data_next  = DataIn;
                    w_isop_next  = IsOp;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!r_isop) begin
                    if (r_depth == FULL) begin
                        w_error_next   = ERR_OVERFLOW;
                        w_display_next = '0;
                        w_state_next   = ST_ERROR;
                    end else begin
                        w_wr_en        = 1'b1;
                        w_depth_next   = r_depth + DW'(1);
                        w_display_next = r_data;
                        w_state_next   = ST_IDLE;
                    end
                end else if (w_check != ERR_NONE) begin
                    w_error_next   = w_check;
                    w_display_next = '0;
                    w_state_next   = ST_ERROR;
                end else begin
                    w_tos_next    = r_stack[w_top_idx];
                    w_nos_next    = (r_depth >= DW'(2)) ? r_stack[w_nos_idx] : '0;
                    w_opcode_next = w_opcode;
                    w_state_next  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_SHOW;
                case (r_opcode)
                    OP_DUP: begin
                        w_wr_en        = 1'b1;
                        w_wr_data      = r_tos;
                        w_depth_next   = r_depth + DW'(1);
                        w_display_next = r_tos;
                    end
                    OP_DROP: begin
                        // r_nos already holds the entry beneath TOS, or 0 if none.
                        w_depth_next   = r_depth - DW'(1);
                        w_display_next = r_nos;
                    end
                    default: begin
                        w_wr_en        = 1'b1;
                        w_wr_idx       = w_nos_idx;
                        w_wr_data      = w_alu_result;
                        w_depth_next   = r_depth - DW'(1);
                        w_flags_next   = w_alu_flags;
                        w_display_next = w_alu_result;
                    end
                endcase
            end
            ST_SHOW: begin
                if (w_edge) w_state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (w_edge) begin
                    w_error_next = ERR_NONE;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_enter_prev <= 1'b0;
            r_data       <= '0;
            r_isop       <= 1'b0;
            r_depth      <= '0;
            r_nos        <= '0;
            r_tos        <= '0;
            r_opcode     <= OP_ADD;
            r_flags      <= '0;
            r_display    <= '0;
            r_error      <= ERR_NONE;
        end else begin
            r_enter_prev <= Enter;
            r_data       <= w_data_next;
            r_isop       <= w_isop_next;
            r_depth      <= w_depth_next;
            r_nos        <= w_nos_next;
            r_tos        <= w_tos_next;
            r_opcode     <= w_opcode_next;
            r_flags      <= w_flags_next;
            r_display    <= w_display_next;
            r_error      <= w_error_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
        end else if (w_wr_en) begin
            r_stack[w_wr_idx] <= w_wr_data;
        end
    end

    assign Flags        = r_flags;
    assign ToDisplay    = r_display;
    assign CurrentState = r_state;
    assign Depth        = r_depth;
    assign Error        = r_error;

endmodule
